// File: rtl/rca_pipe.sv
// Pipelined SEG-bit-per-stage ripple-carry adder/subtractor with valid/ready handshake.
// Define RCA_PIPE_OVF_EN to compute and register signed overflow; otherwise ovf is tied to 0.
module rca_pipe #(
   parameter int WIDTH = 8,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   logic              adv;
   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] cy_q, cy_d;
   logic              sub_q [STAGES];
   logic              sub_d [STAGES];
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  s_q   [STAGES];
   logic [WIDTH-1:0]  s_d   [STAGES];

   logic [WIDTH-1:0]  ain, bin, sin;
   logic              sub_in, cin, vin;
   logic [SEG-1:0]    beff;
   logic [SEG:0]      tot;

`ifdef RCA_PIPE_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   assign adv      = !vld_q[LAST] || out_ready;
   assign in_ready = rst_n && adv;

   // Operands shift right by SEG per stage so each stage works on bits [SEG-1:0];
   // finished sum segments enter at the top and shift down into place.
   always_comb begin
      vld_d  = vld_q;
      cy_d   = cy_q;
      sub_d  = sub_q;
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      ain    = '0;
      bin    = '0;
      sin    = '0;
      sub_in = 1'b0;
      cin    = 1'b0;
      vin    = 1'b0;
      beff   = '0;
      tot    = '0;
`ifdef RCA_PIPE_OVF_EN
      ovf_d  = ovf_q;
`endif
      if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
               ain    = a;
               bin    = b;
               sin    = '0;
               sub_in = sub;
               cin    = c_in ^ sub;
               vin    = in_valid;
            end else begin
               ain    = a_q[k-1];
               bin    = b_q[k-1];
               sin    = s_q[k-1];
               sub_in = sub_q[k-1];
               cin    = cy_q[k-1];
               vin    = vld_q[k-1];
            end
            beff     = bin[SEG-1:0] ^ {SEG{sub_in}};
            tot      = {1'b0, ain[SEG-1:0]} + {1'b0, beff} + {{SEG{1'b0}}, cin};
            vld_d[k] = vin;
            cy_d[k]  = tot[SEG];
            s_d[k]   = (sin >> SEG) | (WIDTH'(tot[SEG-1:0]) << (WIDTH - SEG));
            if (k < LAST) begin
               a_d[k]   = ain >> SEG;
               b_d[k]   = bin >> SEG;
               sub_d[k] = sub_in;
            end
`ifdef RCA_PIPE_OVF_EN
            // carry into the MSB recovered as a ^ b ^ sum at that bit
            if (k == LAST) ovf_d = ain[SEG-1] ^ beff[SEG-1] ^ tot[SEG-1] ^ tot[SEG];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         cy_q  <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            sub_q[k] <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
         end
`ifdef RCA_PIPE_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         vld_q <= vld_d;
         cy_q  <= cy_d;
         sub_q <= sub_d;
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
`ifdef RCA_PIPE_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end

   assign out_valid = vld_q[LAST];
   assign sum       = s_q[LAST];
   assign c_out     = cy_q[LAST];
`ifdef RCA_PIPE_OVF_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=8, SEG=4): directed table, handshake corners,
// and randomized traffic against an arithmetic scoreboard. Honours RCA_PIPE_OVF_EN.
module tb_rca_pipe;

   localparam int W      = 8;
   localparam int S      = 4;
   localparam int STAGES = W / S;
`ifdef RCA_PIPE_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   rca_pipe #(.WIDTH(W), .SEG(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic ci, input logic sb);
      exp_t   e;
      longint r, sr, sa, sbv;
      sa  = longint'($signed(xa));
      sbv = longint'($signed(xb));
      if (!sb) begin
         r  = longint'(xa) + longint'(xb) + longint'(ci);
         sr = sa + sbv + longint'(ci);
         e.c = (r >= (longint'(1) << W));
      end else begin
         r  = longint'(xa) - longint'(xb) - longint'(ci);
         sr = sa - sbv - longint'(ci);
         e.c = (r >= 0);
      end
      e.s = W'(r);
      e.o = OVF_EN && ((sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1))));
      return e;
   endfunction

   exp_t q[$];

   // Scoreboard: every visible result is compared against the oldest outstanding op.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("sb_spurious_out", 32'(out_valid), 32'd0);
            end else begin
               check("sb_sum",   32'(sum),   32'(q[0].s));
               check("sb_c_out", 32'(c_out), 32'(q[0].c));
               check("sb_ovf",   32'(ovf),   32'(q[0].o));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
      end
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } vec_t;

   task automatic apply_one(input vec_t v, input string tag);
      int lat;
      a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(STAGES - 1));
      check({tag, "_sum"},   32'(sum),   32'(v.s));
      check({tag, "_c_out"}, 32'(c_out), 32'(v.c));
      check({tag, "_ovf"},   32'(ovf),   32'(v.o && OVF_EN));
   endtask

   vec_t vt[10];
   vec_t v;
   logic [W-1:0] got[$];

   initial begin
      vt[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      vt[5] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vt[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[8] = '{8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
      vt[9] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum",       32'(sum),       32'd0);
      check("rst_c_out",     32'(c_out),     32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) apply_one(vt[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;

      // Backpressure: five back-to-back adds with out_ready low for three cycles.
      begin
         int n;
         n = 0;
         got.delete();
         for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
            in_valid  = (n < 5);
            a         = 8'h10 + W'(n);
            b         = 8'h01;
            c_in      = 1'b0;
            sub       = 1'b0;
            out_ready = !(cyc >= 2 && cyc < 5);
            @(negedge clk);
            if (!out_ready && out_valid) check("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) n++;
            if (out_valid && out_ready) got.push_back(sum);
            @(posedge clk); #1;
         end
         in_valid = 1'b0; out_ready = 1'b1;
         check("bp_count", 32'(got.size()), 32'd5);
         for (int i = 0; i < got.size() && i < 5; i++)
            check($sformatf("bp_order%0d", i), 32'(got[i]), 32'(8'h11 + i));
      end
      repeat (2) @(posedge clk);
      #1;

      // Reset with two operations in flight.
      a = 8'h20; b = 8'h01; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      a = 8'h30;
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum",       32'(sum),       32'd0);
      check("mid_rst_c_out",     32'(c_out),     32'd0);
      check("mid_rst_ovf",       32'(ovf),       32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("mid_rst_no_stale", 32'(out_valid), 32'd0);
      end
      v = '{8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
      apply_one(v, "post_rst");
      @(posedge clk); #1;

      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = W'($urandom);
         b         = W'($urandom);
         c_in      = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

endmodule

// File: doc/rca_pipe.md
# rca_pipe

Parametrised, pipelined ripple-carry adder/subtractor: the registered, streaming successor to the team's 4-bit combinational `fca`-chain adder. Operands are split into SEG-bit segments, and each segment's ripple chain is resolved in its own pipeline stage, with the carry registered between stages. It accepts one operation per cycle over a valid/ready handshake and is the arithmetic datapath block for the lab's sequential designs.

## Interface
**Parameters**
- `WIDTH`, 8: operand and result width in bits; must be a multiple of `SEG`.
- `SEG`, 4: bits resolved per pipeline stage. `STAGES = WIDTH/SEG` (≥1).

**Ports**
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  block can accept input this cycle.
- `a`  in  WIDTH  operand A (unsigned or two's complement).
- `b`  in  WIDTH  operand B.
- `c_in`  in  1  carry-in (add) / borrow-in (sub).
- `sub`  in  1  0 = add, 1 = subtract.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts result.
- `sum`  out  WIDTH  result.
- `c_out`  out  1  carry-out of MSB.
- `ovf`  out  1  signed overflow (see Configuration).

## Operation
- Add: `{c_out,sum} = a + b + c_in`.
- Sub: `{c_out,sum} = a + ~b + !c_in`, i.e. `a - b - c_in`.
  - `c_out = 1` means no borrow.
- Stage k (0..STAGES-1) adds bits `[k*SEG +: SEG]` of `a` and the effective `b`, using stage k-1's registered carry. Stage 0 uses the effective carry-in.
- Operand skew: upper segments of `a`/`b` and their `sub` flag travel in delay registers, so each segment meets its carry in the correct cycle. Completed lower sum segments are carried forward and de-skewed. `sum` always presents all bits of one operation together.
- `ovf = carry_into_MSB XOR c_out`, computed in the last stage.
- Each stage holds a valid bit. Global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv` (combinational, and 0 while `rst_n` is low).
  - When `adv` is 1, all stages shift one step. Stage 0 loads when `in_valid && in_ready`; otherwise stage 0's valid bit clears (bubble).
  - When `adv` is 0, all stage registers hold.
- Bubbles propagate. No compaction is required.

## Timing
- Reset (`rst_n` sampled low at an edge): all stage valid bits 0, `out_valid=0`, `sum=0`, `c_out=0`, `ovf=0`. Data registers are cleared too. `in_ready=0` during reset and 1 in the first cycle after it is released.
- Latency: an input accepted at edge N appears with `out_valid=1` after edge N+STAGES-1. For STAGES=1 the result is registered and visible after edge N.
- Throughput: 1 operation per cycle when `out_ready` stays high.
- Output stability: while `out_valid && !out_ready`, `sum`, `c_out` and `ovf` hold their values.
- Simultaneous `out_ready` and a new `in_valid` at a full pipe: the output pops and the input is accepted in the same cycle, with no lost or duplicated result.
- Reset mid-operation: all in-flight operations are discarded. No output appears for them.
- Width wrap: `sum` wraps modulo 2^WIDTH. The carry is reported only on `c_out`.

## Configuration
- `RCA_PIPE_OVF_EN` defined:
  - `ovf` is computed as above.
  - The carry-into-MSB is registered alongside the last stage.
- Not defined:
  - `ovf` is tied to 0.
  - No overflow logic or register is synthesised.
  - All other behaviour is identical.

## Test plan
Default parameters: WIDTH=8, SEG=4, STAGES=2.
- Add across a segment boundary: a=0x0F, b=0x01, c_in=0, sub=0 → sum=0x10, c_out=0, ovf=0, with out_valid exactly 1 cycle after the accepting edge.
- Full wrap: a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, ovf=0. Repeat with c_in=1, b=0x00 → same result.
- Signed overflow: a=0x7F, b=0x01 → sum=0x80, ovf=1 with `RCA_PIPE_OVF_EN` and ovf=0 without it.
- Subtract with borrow: sub=1, a=0x05, b=0x07, c_in=0 → sum=0xFE, c_out=0. Then a=0x07, b=0x05, c_in=1 → sum=0x01, c_out=1.
- Backpressure: stream 0x10+0x01 … 0x14+0x01 back-to-back while holding out_ready=0 for 3 cycles mid-stream → in_ready drops, outputs hold, and 0x11…0x15 arrive in order with none lost or duplicated.
- Reset mid-flight: accept 2 operations, pull rst_n low for 1 cycle → all outputs 0, no stale result after release, and a new 0x02+0x03 yields 0x05.
